// File: rtl/serial_rx_param.sv
// Parametrised one-bit-per-clock serial receiver with parity check and a valid/ready output port.
// Define SERIAL_RX_SKID_EN to widen the output stage into a 2-deep in-order FIFO.
module serial_rx_param #(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int LSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_overrun
);

    localparam int              CNT_W      = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam bit              HAS_PARITY = (PARITY_MODE != 0);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        RESYNC
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic              par_acc_reg;
    logic              perr_reg;
    logic              perr_next;
    logic              frame_done;
    logic              pop;

`ifdef SERIAL_RX_SKID_EN
    logic [DATA_W-1:0] tail_data_reg;
    logic              tail_perr_reg;
    logic              full_reg;
    logic              push;
`endif

    // Shift direction decides which end of the word the first data bit lands in.
    generate
        if (DATA_W == 1) begin : g_shift_one
            assign shift_next = i_data;
        end else if (LSB_FIRST != 0) begin : g_shift_lsb
            assign shift_next = {i_data, shift_reg[DATA_W-1:1]};
        end else begin : g_shift_msb
            assign shift_next = {shift_reg[DATA_W-2:0], i_data};
        end
    endgenerate

    // par_acc_reg ^ i_data is 1 when data plus parity bit hold an odd number of ones.
    assign perr_next  = HAS_PARITY && ((PARITY_MODE == 1) ? ~(par_acc_reg ^ i_data)
                                                          :  (par_acc_reg ^ i_data));
    assign frame_done = (state_reg == STOP) && i_data && (cnt_reg == LAST_STOP);
    assign pop        = o_valid && i_ready;

`ifdef SERIAL_RX_SKID_EN
    assign push = frame_done && (!full_reg || pop);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            par_acc_reg   <= 1'b0;
            perr_reg      <= 1'b0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_parity_err  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_overrun     <= 1'b0;
`ifdef SERIAL_RX_SKID_EN
            tail_data_reg <= '0;
            tail_perr_reg <= 1'b0;
            full_reg      <= 1'b0;
`endif
        end else begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (!i_data) begin
                        state_reg   <= DATA;
                        cnt_reg     <= '0;
                        par_acc_reg <= 1'b0;
                        perr_reg    <= 1'b0;
                    end
                end
                DATA: begin
                    shift_reg   <= shift_next;
                    par_acc_reg <= par_acc_reg ^ i_data;
                    if (cnt_reg == LAST_DATA) begin
                        cnt_reg   <= '0;
                        state_reg <= HAS_PARITY ? PARITY : STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                PARITY: begin
                    perr_reg  <= perr_next;
                    state_reg <= STOP;
                end
                STOP: begin
                    // A low stop bit abandons the frame at once; later stop bits are not examined.
                    if (!i_data) begin
                        o_frame_err <= 1'b1;
                        state_reg   <= RESYNC;
                    end else if (cnt_reg == LAST_STOP) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESYNC: begin
                    if (i_data) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

`ifdef SERIAL_RX_SKID_EN
            // o_data/o_parity_err act as the FIFO head, tail_* as the second entry.
            if (pop) begin
                if (full_reg) begin
                    o_data       <= tail_data_reg;
                    o_parity_err <= tail_perr_reg;
                    if (push) begin
                        tail_data_reg <= shift_reg;
                        tail_perr_reg <= perr_reg;
                    end else begin
                        full_reg <= 1'b0;
                    end
                end else if (push) begin
                    o_data       <= shift_reg;
                    o_parity_err <= perr_reg;
                end else begin
                    o_valid <= 1'b0;
                end
            end else if (push) begin
                if (!o_valid) begin
                    o_data       <= shift_reg;
                    o_parity_err <= perr_reg;
                    o_valid      <= 1'b1;
                end else begin
                    tail_data_reg <= shift_reg;
                    tail_perr_reg <= perr_reg;
                    full_reg      <= 1'b1;
                end
            end
            if (frame_done && full_reg && !pop) begin
                o_overrun <= 1'b1;
            end
`else
            if (frame_done) begin
                if (!o_valid || pop) begin
                    o_data       <= shift_reg;
                    o_parity_err <= perr_reg;
                    o_valid      <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (pop) begin
                o_valid <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_serial_rx_param.sv
// Bench for serial_rx_param: default instance plus a 5-bit / even-parity / 2-stop / MSB-first instance.
`timescale 1ns/1ps
module tb_serial_rx_param;

`ifdef SERIAL_RX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam int STRIDE = 1000000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line0, line1, rdy0, rdy1;
    logic [7:0] d0;
    logic [4:0] d1;
    logic       v0, pe0, fe0, ov0;
    logic       v1, pe1, fe1, ov1;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;

    // Expected frame outcomes keyed by inst*STRIDE + edge: 1 = good frame, 2 = framing error.
    int          ev_kind [int];
    logic [15:0] ev_data [int];
    bit          ev_perr [int];

    // Reference output queue per instance, at most CAP entries.
    logic [15:0] qd [2][2];
    bit          qp [2][2];
    int          qn [2];
    bit          m_ferr [2];
    bit          m_ovr [2];

    always #5 clk = ~clk;

    serial_rx_param u0 (
        .clk(clk), .rst_n(rst_n), .i_data(line0), .o_data(d0), .o_valid(v0),
        .i_ready(rdy0), .o_parity_err(pe0), .o_frame_err(fe0), .o_overrun(ov0)
    );

    serial_rx_param #(.DATA_W(5), .PARITY_MODE(2), .STOP_BITS(2), .LSB_FIRST(0)) u1 (
        .clk(clk), .rst_n(rst_n), .i_data(line1), .o_data(d1), .o_valid(v1),
        .i_ready(rdy1), .o_parity_err(pe1), .o_frame_err(fe1), .o_overrun(ov1)
    );

    function automatic int pw(input int i);  return (i == 0) ? 8 : 5; endfunction
    function automatic int pm(input int i);  return (i == 0) ? 1 : 2; endfunction
    function automatic int ps(input int i);  return (i == 0) ? 1 : 2; endfunction
    function automatic bit plsb(input int i); return (i == 0); endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input int i, input bit rdy);
        int key;
        bit pop;
        m_ferr[i] = 1'b0;
        m_ovr[i]  = 1'b0;
        if (!rst_n) begin
            qn[i] = 0;
            return;
        end
        pop = (qn[i] > 0) && rdy;
        if (pop) begin
            qd[i][0] = qd[i][1];
            qp[i][0] = qp[i][1];
            qn[i]--;
        end
        key = i * STRIDE + edge_cnt;
        if (ev_kind.exists(key)) begin
            if (ev_kind[key] == 2) begin
                m_ferr[i] = 1'b1;
            end else if (qn[i] < CAP) begin
                qd[i][qn[i]] = ev_data[key];
                qp[i][qn[i]] = ev_perr[key];
                qn[i]++;
            end else begin
                m_ovr[i] = 1'b1;
            end
            ev_kind.delete(key);
        end
    endtask

    task automatic compare(input int i, input logic [15:0] d, input logic v,
                           input logic pe, input logic fe, input logic ov);
        string tag;
        tag = (i == 0) ? "u0" : "u1";
        chk({tag, ".valid"}, v, qn[i] > 0);
        if (qn[i] > 0) begin
            chk({tag, ".data"}, d, qd[i][0]);
            chk({tag, ".perr"}, pe, qp[i][0]);
        end
        chk({tag, ".frame_err"}, fe, m_ferr[i]);
        chk({tag, ".overrun"}, ov, m_ovr[i]);
    endtask

    // Single compare process: advance the reference on each rising edge, then check just after it.
    initial begin
        qn[0] = 0;
        qn[1] = 0;
        forever begin
            @(posedge clk);
            model_edge(0, rdy0);
            model_edge(1, rdy1);
            edge_cnt++;
            #1;
            compare(0, {8'b0, d0}, v0, pe0, fe0, ov0);
            compare(1, {11'b0, d1}, v1, pe1, fe1, ov1);
        end
    end

    // Called at a falling edge: present one bit and wait for the next falling edge.
    task automatic drive(input int i, input bit b);
        if (i == 0) line0 = b;
        else        line1 = b;
        @(negedge clk);
    endtask

    task automatic send_frame(input int i, input logic [15:0] data, input bit par,
                              input bit st1, input bit st2);
        int w, p, s, base, key, ones;
        logic [15:0] word;
        w    = pw(i);
        p    = (pm(i) != 0) ? 1 : 0;
        s    = ps(i);
        base = i * STRIDE + edge_cnt;
        word = data & ((16'd1 << w) - 16'd1);
        ones = $countones(word) + int'(par);
        if (!st1) begin
            ev_kind[base + w + p + 1] = 2;
        end else if (s == 2 && !st2) begin
            ev_kind[base + w + p + 2] = 2;
        end else begin
            key          = base + w + p + s;
            ev_kind[key] = 1;
            ev_data[key] = word;
            ev_perr[key] = (p == 0) ? 1'b0 : (pm(i) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        end
        drive(i, 1'b0);
        for (int k = 0; k < w; k++) begin
            drive(i, plsb(i) ? word[k] : word[w-1-k]);
        end
        if (p != 0) drive(i, par);
        drive(i, st1);
        if (s == 2) drive(i, st2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        line0 = 1'b1;
        line1 = 1'b1;
        rdy0  = 1'b1;
        rdy1  = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.valid", v0, 1'b0);
        chk("reset.data", d0, 8'h00);
        chk("reset.frame_err", fe0, 1'b0);
        chk("reset.overrun", ov0, 1'b0);
        rst_n = 1'b1;
        drive(0, 1'b1);
        drive(0, 1'b1);

        // Good 0xA5, odd parity satisfied.
        send_frame(0, 16'hA5, 1'b1, 1'b1, 1'b0);
        chk("a5.valid", v0, 1'b1);
        chk("a5.data", d0, 8'hA5);
        chk("a5.perr", pe0, 1'b0);
        drive(0, 1'b1);
        chk("a5.valid_one_cycle", v0, 1'b0);

        // Parity error is delivered, not dropped.
        send_frame(0, 16'hA5, 1'b0, 1'b1, 1'b0);
        chk("a5p.valid", v0, 1'b1);
        chk("a5p.perr", pe0, 1'b1);
        drive(0, 1'b1);

        // Bad stop bit, line low in resync, then a clean 0x3C.
        send_frame(0, 16'hA5, 1'b1, 1'b0, 1'b0);
        chk("ferr.pulse", fe0, 1'b1);
        chk("ferr.no_valid", v0, 1'b0);
        repeat (5) drive(0, 1'b0);
        drive(0, 1'b1);
        send_frame(0, 16'h3C, 1'b1, 1'b1, 1'b0);
        chk("3c.valid", v0, 1'b1);
        chk("3c.data", d0, 8'h3C);
        drive(0, 1'b1);

        // Back-to-back frames with consumer stalled.
        rdy0 = 1'b0;
        send_frame(0, 16'h11, 1'b1, 1'b1, 1'b0);
        send_frame(0, 16'h22, 1'b1, 1'b1, 1'b0);
        chk("ovr.head", d0, 8'h11);
`ifdef SERIAL_RX_SKID_EN
        chk("ovr.none", ov0, 1'b0);
`else
        chk("ovr.pulse", ov0, 1'b1);
`endif
        drive(0, 1'b1);
        chk("ovr.one_cycle", ov0, 1'b0);
        chk("ovr.held", d0, 8'h11);
        rdy0 = 1'b1;
        drive(0, 1'b1);
`ifdef SERIAL_RX_SKID_EN
        chk("skid.second", d0, 8'h22);
        chk("skid.valid", v0, 1'b1);
        drive(0, 1'b1);
`endif
        chk("drain.valid", v0, 1'b0);

        // Narrow MSB-first instance: 0x13 = 10011, even parity bit 1, two stops.
        send_frame(1, 16'h13, 1'b1, 1'b1, 1'b1);
        chk("w5.valid", v1, 1'b1);
        chk("w5.data", d1, 5'h13);
        chk("w5.perr", pe1, 1'b0);
        drive(1, 1'b1);
        send_frame(1, 16'h13, 1'b0, 1'b1, 1'b1);
        chk("w5p.perr", pe1, 1'b1);
        drive(1, 1'b1);
        send_frame(1, 16'h13, 1'b1, 1'b1, 1'b0);
        chk("w5.stop2_ferr", fe1, 1'b1);
        chk("w5.stop2_no_valid", v1, 1'b0);
        drive(1, 1'b1);
        drive(1, 1'b1);

        // Reset during data bit 4 with a frame still pending at the output.
        rdy0 = 1'b0;
        send_frame(0, 16'h5A, 1'b1, 1'b1, 1'b0);
        chk("rst.pending", v0, 1'b1);
        drive(0, 1'b0);
        drive(0, 1'b0);
        drive(0, 1'b0);
        drive(0, 1'b0);
        drive(0, 1'b0);
        line0 = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst.valid", v0, 1'b0);
        chk("rst.data", d0, 8'h00);
        chk("rst.perr", pe0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdy0  = 1'b1;
        drive(0, 1'b1);
        drive(0, 1'b1);
        send_frame(0, 16'hC3, 1'b1, 1'b1, 1'b0);
        chk("post_rst.valid", v0, 1'b1);
        chk("post_rst.data", d0, 8'hC3);
        drive(0, 1'b1);
        drive(0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_rx_param.md
# serial_rx_param

Parametrised single-line serial receiver. Each frame is a start bit, DATA_W data bits, an optional parity bit (odd or even) and one or two stop bits, sampled one bit per clock. Completed frames go to a valid/ready output port with per-frame parity-error flags, plus framing-error and overrun pulses. It is the general-purpose successor to the fixed 8-bit odd-parity receiver and sits between a serial pin synchroniser and a byte-stream consumer.

## Interface
- DATA_W, 8, data bits per frame, legal 1..16
- PARITY_MODE, 1, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, stop bits per frame, legal 1 or 2
- LSB_FIRST, 1, 1: first data bit goes to o_data[0]; 0: first data bit goes to o_data[DATA_W-1]
- clk  input  1  clock; all sampling on rising edge
- rst_n  input  1  asynchronous, active-low reset
- i_data  input  1  serial line, idle high, already synchronised
- o_data  output  DATA_W  received data word
- o_valid  output  1  o_data/o_parity_err hold a complete frame
- i_ready  input  1  consumer accepts on the edge where o_valid && i_ready
- o_parity_err  output  1  parity mismatch for the presented frame; meaningful only while o_valid
- o_frame_err  output  1  one-cycle pulse: a stop bit was sampled 0
- o_overrun  output  1  one-cycle pulse: a completed frame was dropped

## Operation
- States: IDLE, DATA, PARITY, STOP, RESYNC.
- IDLE: i_data=0 at an edge counts as the start bit; go to DATA and clear the bit counter.
- DATA: sample one bit per edge into the shift register. After DATA_W bits, go to PARITY, or to STOP if PARITY_MODE=0.
- PARITY: sample one bit and go to STOP.
  - Odd mode: error if the data plus parity bit hold an even number of ones.
  - Even mode: error if they hold an odd number of ones.
- STOP: sample STOP_BITS bits.
  - If any stop bit is 0: pulse o_frame_err, discard the frame, go to RESYNC immediately (remaining stop bits are not sampled).
  - If all stop bits are 1: the frame completes; go to IDLE.
- RESYNC: stay until i_data=1 is sampled, then go to IDLE. A 0 in RESYNC is never taken as a start bit.
- Frame completion writes the word and the parity flag into the output register. Parity-error frames are delivered with o_parity_err=1, not dropped.
- With PARITY_MODE=0, o_parity_err is tied to 0.
- Overrun: a frame completes while the output register is full and no transfer happens on that edge.
  - The new frame is dropped, the held data is unchanged, and o_overrun pulses.
- Simultaneous completion and transfer (o_valid && i_ready on the completion edge): the new frame is loaded and o_valid stays 1. No overrun.
- Back-to-back frames: a start bit sampled on the edge immediately after the last stop bit is accepted.
- The bit counter is sized as clog2(DATA_W+1) bits and never wraps past DATA_W.

## Timing
- Reset values: state IDLE; o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_overrun=0.
- Bit positions, with the start bit sampled at edge 0:
  - data bit k at edge k+1;
  - parity bit at edge DATA_W+1;
  - stop bits at the following edges.
- o_valid, o_frame_err and o_overrun are registered. Each asserts in the cycle after the edge that samples the last stop bit (or the failing stop bit).
- Default parameters: o_valid goes high after edge 10.
- o_frame_err and o_overrun are high for exactly one cycle.
- o_data and o_parity_err stay stable while o_valid && !i_ready.
- o_valid drops in the cycle after an accepting edge, unless a new frame loads on that same edge.
- Reset asserted mid-frame or with data pending:
  - immediately clears all state and buffers;
  - the partial frame is lost;
  - no pulse is generated.

## Configuration
- SERIAL_RX_SKID_EN defined: adds a second output entry, giving a 2-deep FIFO that delivers frames in order.
  - Overrun occurs only when both entries are full and no pop happens on the completion edge.
  - o_valid reflects the non-empty condition of the FIFO.
- SERIAL_RX_SKID_EN undefined: a single output register with the drop-on-full overrun rule above.

## Test plan
- Default parameters, line 0, bits of 0xA5 LSB-first, parity bit 1, stop bit 1, i_ready=1 -> o_valid high for one cycle after edge 10, o_data=0xA5, o_parity_err=0.
- Same frame with parity bit 0 -> o_data=0xA5 delivered with o_parity_err=1.
- Same frame with stop bit 0, then line held low 5 cycles, then high, then a valid 0x3C frame:
  - o_frame_err pulses once and no o_valid for the bad frame;
  - the 0x3C frame is received correctly.
- i_ready=0, frames 0x11 then 0x22 back-to-back:
  - macro undefined: o_data stays 0x11 and o_overrun pulses after the second frame's stop edge;
  - macro defined: no overrun, and raising i_ready yields 0x11 then 0x22.
- DATA_W=5, PARITY_MODE=2, STOP_BITS=2, send 0x13, parity bit 1, stops 1,1 -> o_valid after edge 8, o_data=0x13, o_parity_err=0. Second stop bit 0 instead -> o_frame_err pulse.
- rst_n pulsed low during data bit 4 of a frame -> all outputs 0 during reset, no o_valid for that frame, and the next full frame is received correctly.
